// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: bus widths, field indices and decoded-bus layout shared by the execute stage.
package exe_stage_pkg;
    localparam int DS_TO_ES_BUS_WD = 168;
    localparam int ES_TO_MS_BUS_WD = 78;
    localparam int ES_TO_FW_BUS_WD = 39;
    localparam int FW_TO_ES_BUS_WD = 66;
    localparam int BR_BUS_WD       = 33;

    localparam int ALU_OP_ADD  = 0;
    localparam int ALU_OP_SUB  = 1;
    localparam int ALU_OP_SLT  = 2;
    localparam int ALU_OP_SLTU = 3;
    localparam int ALU_OP_AND  = 4;
    localparam int ALU_OP_NOR  = 5;
    localparam int ALU_OP_OR   = 6;
    localparam int ALU_OP_XOR  = 7;
    localparam int ALU_OP_SLL  = 8;
    localparam int ALU_OP_SRL  = 9;
    localparam int ALU_OP_SRA  = 10;
    localparam int ALU_OP_LUI  = 11;

    localparam int BR_BEQ  = 0;
    localparam int BR_BNE  = 1;
    localparam int BR_BLT  = 2;
    localparam int BR_BGE  = 3;
    localparam int BR_BLTU = 4;
    localparam int BR_BGEU = 5;
    localparam int BR_B    = 6;
    localparam int BR_BL   = 7;
    localparam int BR_JIRL = 8;

    // load_op is {ld.hu, ld.bu, ld.w, ld.h, ld.b}; store_op is {st.w, st.h, st.b}
    localparam int LD_H  = 1;
    localparam int LD_W  = 2;
    localparam int LD_HU = 4;
    localparam int ST_B  = 0;
    localparam int ST_H  = 1;
    localparam int ST_W  = 2;

    typedef struct packed {
        logic [11:0] alu_op;
        logic        src1_is_pc;
        logic        src2_is_imm;
        logic        src2_is_4;
        logic        mem_to_reg;
        logic        reg_we;
        logic        mem_we;
        logic [4:0]  load_op;
        logic [2:0]  store_op;
        logic [8:0]  branch_op;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
    } ds_bus_t;

    function automatic logic [3:0] st_strobe(input logic [2:0] st_op, input logic [1:0] lo);
        return st_op[ST_B] ? 4'b0001 << lo : st_op[ST_H] ? (lo[1] ? 4'b1100 : 4'b0011) : {4{st_op[ST_W]}};
    endfunction

    function automatic logic misaligned(input logic [4:0] ld_op, input logic [2:0] st_op, input logic [1:0] lo);
        return ((ld_op[LD_W] | st_op[ST_W]) & (|lo)) | ((ld_op[LD_H] | ld_op[LD_HU] | st_op[ST_H]) & lo[0]);
    endfunction
endpackage

// File: rtl/exe_alu.sv
// exe_alu: combinational one-hot 12-op integer ALU; an all-zero op vector yields 0.
module exe_alu
    import exe_stage_pkg::*;
(
    input  logic [11:0] i_alu_op,
    input  logic [31:0] i_src1,
    input  logic [31:0] i_src2,
    output logic [31:0] o_result
);
    logic [4:0]  w_sa;
    logic [31:0] w_sra;

    assign w_sa  = i_src2[4:0];
    // kept separate so the surrounding unsigned mask logic cannot turn >>> into a logical shift
    assign w_sra = $signed(i_src1) >>> w_sa;

    assign o_result = ({32{i_alu_op[ALU_OP_ADD]}}  & (i_src1 + i_src2))
                    | ({32{i_alu_op[ALU_OP_SUB]}}  & (i_src1 - i_src2))
                    | ({32{i_alu_op[ALU_OP_SLT]}}  & {31'd0, $signed(i_src1) < $signed(i_src2)})
                    | ({32{i_alu_op[ALU_OP_SLTU]}} & {31'd0, i_src1 < i_src2})
                    | ({32{i_alu_op[ALU_OP_AND]}}  & (i_src1 & i_src2))
                    | ({32{i_alu_op[ALU_OP_NOR]}}  & ~(i_src1 | i_src2))
                    | ({32{i_alu_op[ALU_OP_OR]}}   & (i_src1 | i_src2))
                    | ({32{i_alu_op[ALU_OP_XOR]}}  & (i_src1 ^ i_src2))
                    | ({32{i_alu_op[ALU_OP_SLL]}}  & (i_src1 << w_sa))
                    | ({32{i_alu_op[ALU_OP_SRL]}}  & (i_src1 >> w_sa))
                    | ({32{i_alu_op[ALU_OP_SRA]}}  & w_sra)
                    | ({32{i_alu_op[ALU_OP_LUI]}}  & i_src2);
endmodule

// File: rtl/exe_stage.sv
// exe_stage: LoongArch32 execute stage -- forwarding mux, ALU, branch resolve, data-SRAM request.
// Define EXE_MISALIGN_CHK_EN to suppress misaligned word/halfword accesses and pulse es_ale.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    input  logic [FW_TO_ES_BUS_WD-1:0] fw_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [ES_TO_FW_BUS_WD-1:0] es_to_fw_bus,
    output logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata,
    output logic                       es_ale
);
    logic        r_es_valid, r_br_done, r_kill_next;
    ds_bus_t     r_ds;
    logic        w_fwd1_en, w_fwd2_en, w_accept, w_handoff, w_eq, w_lt, w_ltu;
    logic        w_br_cond, w_br_taken, w_misalign;
    logic [31:0] w_fwd1, w_fwd2, w_op1, w_op2, w_src1, w_src2, w_result, w_br_target;

    assign {w_fwd1_en, w_fwd1, w_fwd2_en, w_fwd2} = fw_to_es_bus;
    assign w_op1  = w_fwd1_en ? w_fwd1 : r_ds.rs1;
    assign w_op2  = w_fwd2_en ? w_fwd2 : r_ds.rs2;
    assign w_src1 = r_ds.src1_is_pc ? r_ds.pc : w_op1;
    assign w_src2 = r_ds.src2_is_4 ? 32'd4 : r_ds.src2_is_imm ? r_ds.imm : w_op2;

    exe_alu u_alu (
        .i_alu_op (r_ds.alu_op),
        .i_src1   (w_src1),
        .i_src2   (w_src2),
        .o_result (w_result)
    );

    assign es_allowin     = !r_es_valid | ms_allowin;
    assign es_to_ms_valid = r_es_valid;
    assign w_accept       = es_allowin & ds_to_es_valid;
    assign w_handoff      = r_es_valid & ms_allowin;

    assign w_eq  = w_op1 == w_op2;
    assign w_lt  = $signed(w_op1) < $signed(w_op2);
    assign w_ltu = w_op1 < w_op2;
    assign w_br_cond = (r_ds.branch_op[BR_BEQ] & w_eq) | (r_ds.branch_op[BR_BNE] & !w_eq)
                     | (r_ds.branch_op[BR_BLT] & w_lt) | (r_ds.branch_op[BR_BGE] & !w_lt)
                     | (r_ds.branch_op[BR_BLTU] & w_ltu) | (r_ds.branch_op[BR_BGEU] & !w_ltu)
                     | r_ds.branch_op[BR_B] | r_ds.branch_op[BR_BL] | r_ds.branch_op[BR_JIRL];
    // br_done keeps a stalled branch from redirecting fetch more than once
    assign w_br_taken  = r_es_valid & w_br_cond & !r_br_done;
    assign w_br_target = (r_ds.branch_op[BR_JIRL] ? w_op1 : r_ds.pc) + r_ds.imm;
    assign br_bus      = {w_br_taken, w_br_target};

`ifdef EXE_MISALIGN_CHK_EN
    assign w_misalign = misaligned(r_ds.load_op, r_ds.store_op, w_result[1:0]);
    assign es_ale     = w_handoff & w_misalign;
`else
    assign w_misalign = 1'b0;
    assign es_ale     = 1'b0;
`endif

    // request only on the handoff cycle so a stalled access issues exactly once
    assign data_sram_en    = w_handoff & (r_ds.mem_we | r_ds.mem_to_reg) & !w_misalign;
    assign data_sram_we    = (data_sram_en & r_ds.mem_we) ? st_strobe(r_ds.store_op, w_result[1:0]) : 4'h0;
    assign data_sram_addr  = w_result;
    assign data_sram_wdata = r_ds.store_op[ST_B] ? {4{w_op2[7:0]}} : r_ds.store_op[ST_H] ? {2{w_op2[15:0]}} : w_op2;

    assign es_to_ms_bus = {r_ds.mem_to_reg, r_ds.reg_we & !w_misalign, r_ds.load_op, w_result[1:0],
                           r_ds.dest, w_result, r_ds.pc};
    assign es_to_fw_bus = {r_es_valid & r_ds.reg_we, r_ds.dest, w_result, r_es_valid & r_ds.mem_to_reg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_es_valid  <= 1'b0;
            r_ds        <= '0;
            r_br_done   <= 1'b0;
            r_kill_next <= 1'b0;
        end else begin
            if (es_allowin)
                r_es_valid <= ds_to_es_valid & !(w_br_taken | r_kill_next);
            if (w_accept)
                r_ds <= ds_to_es_bus;
            r_br_done   <= w_handoff ? 1'b0 : (w_br_taken | r_br_done);
            r_kill_next <= w_br_taken ? !w_accept : (r_kill_next & !w_accept);
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed bench for exe_stage; a queue of expected ALU results/PCs is checked at every ms handoff.
module tb_exe_stage;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ms_allowin = 1'b1;
    logic         es_allowin;
    logic         ds_to_es_valid = 1'b0;
    logic [167:0] ds_to_es_bus = '0;
    logic [65:0]  fw_to_es_bus = '0;
    logic         es_to_ms_valid;
    logic [77:0]  es_to_ms_bus;
    logic [38:0]  es_to_fw_bus;
    logic [32:0]  br_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         es_ale;

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .fw_to_es_bus    (fw_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_to_fw_bus    (es_to_fw_bus),
        .br_bus          (br_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .es_ale          (es_ale)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] A_ADD = 12'h001, A_SUB = 12'h002, A_SLT = 12'h004, A_SLTU = 12'h008;
    localparam logic [11:0] A_AND = 12'h010, A_NOR = 12'h020, A_OR = 12'h040, A_XOR = 12'h080;
    localparam logic [11:0] A_SLL = 12'h100, A_SRL = 12'h200, A_SRA = 12'h400, A_LUI = 12'h800;
    // flags: {src1_is_pc, src2_is_imm, src2_is_4, mem_to_reg, reg_we, mem_we}
    localparam logic [5:0] F_PC = 6'b100000, F_IMM = 6'b010000, F_4 = 6'b001000;
    localparam logic [5:0] F_M2R = 6'b000100, F_WE = 6'b000010, F_MWE = 6'b000001;
    localparam logic [8:0] B_BEQ = 9'h001, B_BNE = 9'h002, B_JIRL = 9'h100;
    localparam logic [4:0] L_W = 5'b00100;
    localparam logic [2:0] S_B = 3'b001, S_H = 3'b010, S_W = 3'b100;

    logic [11:0] t_op [13] = '{A_ADD, A_SUB, A_SLT, A_SLTU, A_AND, A_NOR, A_OR, A_XOR,
                               A_SLL, A_SRL, A_SRA, A_LUI, 12'h000};
    logic [31:0] t_a [13] = '{32'd7, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F01234, 32'hF0F00000,
                              32'h1200, 32'hFF00FF00, 32'd1, 32'h80000000, 32'h80000000, 32'd7, 32'd9};
    logic [31:0] t_b [13] = '{32'hFFFFFFFD, 32'd7, 32'd1, 32'd1, 32'h0FF0FFFF, 32'h0F0F0000,
                              32'h34, 32'h0FF00FF0, 32'd35, 32'd4, 32'd4, 32'h12345000, 32'd9};
    logic [31:0] t_r [13] = '{32'd4, 32'hFFFFFFFE, 32'd1, 32'd0, 32'h00F01234, 32'h0000FFFF,
                              32'h1234, 32'hF0F0F0F0, 32'd8, 32'h08000000, 32'hF8000000, 32'h12345000, 32'd0};

    typedef struct {
        logic [31:0] res;
        logic [31:0] pc;
    } exp_t;
    exp_t sb_q [$];

    int n_pass = 0;
    int n_total = 0;
    int br_cnt;
    int en_cnt;

    function automatic logic [167:0] mk(input logic [11:0] alu, input logic [5:0] fl, input logic [4:0] ld,
                                        input logic [2:0] st, input logic [8:0] br, input logic [4:0] dst,
                                        input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                                        input logic [31:0] pc);
        return {alu, fl, ld, st, br, dst, imm, rs1, rs2, pc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input logic [31:0] res, input logic [31:0] pc);
        exp_t e;
        e.res = res;
        e.pc  = pc;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [167:0] bus);
        ds_to_es_valid = v;
        ds_to_es_bus   = bus;
    endtask

    // settle, then score any instruction leaving for ms this cycle
    task automatic sample();
        exp_t e;
        #3;
        if (es_to_ms_valid && ms_allowin) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_result", es_to_ms_bus[63:32], e.res);
                chk("sb_pc", es_to_ms_bus[31:0], e.pc);
            end
        end
    endtask

    initial begin
        logic [31:0] pc_i;
        // reset state
        step();
        step();
        #3;
        chk("rst_valid", es_to_ms_valid, 0);
        chk("rst_sram_en", data_sram_en, 0);
        chk("rst_sram_we", data_sram_we, 0);
        chk("rst_br_taken", br_bus[32], 0);
        chk("rst_ale", es_ale, 0);
        chk("rst_fw_we", es_to_fw_bus[38], 0);
        chk("rst_fw_m2r", es_to_fw_bus[0], 0);
        chk("rst_allowin", es_allowin, 1);
        step();
        reset = 1'b0;

        // add.w 7 + -3
        step();
        drive(1, mk(A_ADD, F_WE, 0, 0, 0, 5'd5, 0, 32'd7, 32'hFFFFFFFD, 32'h1C000000));
        push(32'd4, 32'h1C000000);
        sample();
        chk("add_allowin", es_allowin, 1);
        step();
        drive(0, '0);
        sample();
        chk("add_valid", es_to_ms_valid, 1);
        chk("add_fw_we", es_to_fw_bus[38], 1);
        chk("add_fw_dest", es_to_fw_bus[37:33], 5);
        chk("add_fw_res", es_to_fw_bus[32:1], 4);
        chk("add_sram_en", data_sram_en, 0);

        // back-to-back ALU table: each cycle accepts one instruction while the previous hands off
        for (int i = 0; i < 13; i++) begin
            step();
            pc_i = 32'h1C000100 + 32'(4 * i);
            drive(1, mk(t_op[i], F_WE, 0, 0, 0, 5'd3, 0, t_a[i], t_b[i], pc_i));
            push(t_r[i], pc_i);
            sample();
        end
        step();
        drive(0, '0);
        sample();

        // slti with rs1 overridden by forwarding: 5 < 6
        step();
        drive(1, mk(A_SLT, F_WE | F_IMM, 0, 0, 0, 5'd6, 32'd6, 32'd9, 32'd0, 32'h1C000200));
        push(32'd1, 32'h1C000200);
        sample();
        step();
        drive(0, '0);
        fw_to_es_bus = {1'b1, 32'd5, 1'b0, 32'd0};
        sample();
        step();
        fw_to_es_bus = '0;

        // beq taken while ms stalls 3 cycles; next ds instruction must be dropped
        drive(1, mk(12'h000, 6'b0, 0, 0, B_BEQ, 5'd0, 32'h20, 32'h55, 32'h55, 32'h1C000010));
        push(32'd0, 32'h1C000010);
        sample();
        br_cnt = 0;
        step();
        ms_allowin = 1'b0;
        drive(1, mk(A_ADD, F_WE, 0, 0, 0, 5'd7, 0, 32'd100, 32'd100, 32'h1C000014));
        sample();
        br_cnt += int'(br_bus[32]);
        chk("beq_taken", br_bus[32], 1);
        chk("beq_target", br_bus[31:0], 32'h1C000030);
        chk("beq_stall_allowin", es_allowin, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            sample();
            br_cnt += int'(br_bus[32]);
        end
        step();
        ms_allowin = 1'b1;
        sample();
        br_cnt += int'(br_bus[32]);
        chk("beq_pulses", br_cnt, 1);
        step();
        drive(0, '0);
        sample();
        chk("beq_wrong_path_dropped", es_to_ms_valid, 0);
        step();
        drive(1, mk(A_ADD, F_WE, 0, 0, 0, 5'd8, 0, 32'd1, 32'd2, 32'h1C000030));
        push(32'd3, 32'h1C000030);
        sample();
        step();
        drive(0, '0);
        sample();
        chk("beq_target_insn_valid", es_to_ms_valid, 1);

        // jirl: link = pc+4, target = rs1+imm, wrong-path accepted in the same cycle is dropped
        step();
        drive(1, mk(A_ADD, F_PC | F_4 | F_WE, 0, 0, B_JIRL, 5'd1, 32'd8, 32'h1C001000, 0, 32'h1C000040));
        push(32'h1C000044, 32'h1C000040);
        sample();
        step();
        drive(1, mk(A_ADD, F_WE, 0, 0, 0, 5'd9, 0, 32'd1, 32'd1, 32'h1C000044));
        sample();
        chk("jirl_taken", br_bus[32], 1);
        chk("jirl_target", br_bus[31:0], 32'h1C001008);
        step();
        drive(0, '0);
        sample();
        chk("jirl_dropped", es_to_ms_valid, 0);
        chk("jirl_no_repeat", br_bus[32], 0);
        step();
        drive(1, mk(12'h000, 6'b0, 0, 0, B_BNE, 5'd0, 32'h40, 32'h77, 32'h77, 32'h1C001008));
        push(32'd0, 32'h1C001008);
        sample();
        step();
        drive(0, '0);
        sample();
        chk("bne_not_taken", br_bus[32], 0);

        // st.h to 0x1002 with a two-cycle ms stall
        step();
        drive(1, mk(A_ADD, F_IMM | F_MWE, 0, S_H, 0, 5'd0, 32'd2, 32'h1000, 32'h1234ABCD, 32'h1C002000));
        push(32'h1002, 32'h1C002000);
        sample();
        en_cnt = 0;
        step();
        drive(0, '0);
        ms_allowin = 1'b0;
        sample();
        en_cnt += int'(data_sram_en);
        step();
        sample();
        en_cnt += int'(data_sram_en);
        step();
        ms_allowin = 1'b1;
        sample();
        en_cnt += int'(data_sram_en);
        chk("sth_en", data_sram_en, 1);
        chk("sth_we", data_sram_we, 4'b1100);
        chk("sth_wdata", data_sram_wdata, 32'hABCDABCD);
        chk("sth_addr", data_sram_addr, 32'h1002);
        chk("sth_en_pulses", en_cnt, 1);
        step();
        sample();
        chk("sth_en_after", data_sram_en, 0);

        // st.b to 0x1003 followed immediately by st.w to 0x1004
        step();
        drive(1, mk(A_ADD, F_IMM | F_MWE, 0, S_B, 0, 5'd0, 32'd3, 32'h1000, 32'h1234ABCD, 32'h1C002010));
        push(32'h1003, 32'h1C002010);
        sample();
        step();
        drive(1, mk(A_ADD, F_IMM | F_MWE, 0, S_W, 0, 5'd0, 32'd4, 32'h1000, 32'h1234ABCD, 32'h1C002014));
        push(32'h1004, 32'h1C002014);
        sample();
        chk("stb_we", data_sram_we, 4'b1000);
        chk("stb_wdata", data_sram_wdata, 32'hCDCDCDCD);
        step();
        drive(0, '0);
        sample();
        chk("stw_we", data_sram_we, 4'hF);
        chk("stw_wdata", data_sram_wdata, 32'h1234ABCD);

        // ld.w at misaligned 0x1001
        step();
        drive(1, mk(A_ADD, F_IMM | F_M2R | F_WE, L_W, 0, 0, 5'd4, 32'd1, 32'h1000, 0, 32'h1C002020));
        push(32'h1001, 32'h1C002020);
        sample();
        step();
        drive(0, '0);
        sample();
        chk("ldw_we", data_sram_we, 0);
        chk("ldw_addr", data_sram_addr, 32'h1001);
        chk("ldw_addr_lo", es_to_ms_bus[70:69], 2'b01);
`ifdef EXE_MISALIGN_CHK_EN
        chk("ldw_ale", es_ale, 1);
        chk("ldw_en", data_sram_en, 0);
        chk("ldw_reg_we", es_to_ms_bus[76], 0);
`else
        chk("ldw_ale", es_ale, 0);
        chk("ldw_en", data_sram_en, 1);
        chk("ldw_reg_we", es_to_ms_bus[76], 1);
`endif

        // reset in the middle of a stalled st.w
        step();
        drive(1, mk(A_ADD, F_IMM | F_MWE, 0, S_W, 0, 5'd0, 32'd0, 32'h2000, 32'h5A5A5A5A, 32'h1C002030));
        push(32'h2000, 32'h1C002030);
        sample();
        step();
        drive(0, '0);
        ms_allowin = 1'b0;
        sample();
        chk("stall_valid", es_to_ms_valid, 1);
        chk("stall_en", data_sram_en, 0);
        step();
        #1;
        reset = 1'b1;
        #1;
        chk("rst_async_valid", es_to_ms_valid, 0);
        void'(sb_q.pop_back());
        step();
        step();
        reset = 1'b0;
        ms_allowin = 1'b1;
        en_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            sample();
            en_cnt += int'(data_sram_en) + int'(es_to_ms_valid);
        end
        chk("rst_no_request", en_cnt, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
